doodle_motion: RTL and testbench
================================

# doodle_motion

Parametrised player-motion engine for the Doodle Jump datapath: an IDLE/FLY/DEAD state machine with signed vertical velocity, gravity, platform bounce, horizontal wrap, camera scroll and score. It sits between the keyboard decoder and collision unit (inputs) and the sprite renderer and platform scroller (outputs). Every state update happens on a single-cycle `frame_tick`.

## Interface
- COORD_W, 10, coordinate width (unsigned)
- VEL_W, 6, vertical velocity width (two's complement)
- SCORE_W, 16, score width
- SCREEN_H, 240, screen height
- SPRITE_W, 10, sprite width
- SPRITE_H, 10, sprite height
- X_MIN, 80, left playfield bound
- X_MAX, 239, right playfield bound
- START_X, 155, spawn X
- START_Y, 160, spawn Y
- SCROLL_LINE, 80, highest Y the sprite may occupy; above this the world scrolls
- X_STEP, 1, horizontal pixels per frame
- GRAVITY, 1, velocity increment per frame
- JUMP_V, 9, jump/bounce speed (velocity is set to -JUMP_V)
- VMAX_DOWN, 3, terminal downward velocity
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame
- left  in  1  move-left request (level)
- right  in  1  move-right request (level)
- start  in  1  start/restart pulse
- plat_hit  in  1  sprite feet overlap a platform (valid when `frame_tick` is high)
- pos_x  out  COORD_W  sprite X
- pos_y  out  COORD_W  sprite Y
- vel_y  out  VEL_W  signed vertical velocity
- scroll_dy  out  COORD_W  scroll amount of the last frame
- scroll_valid  out  1  one-cycle pulse when `scroll_dy` has been updated
- score  out  SCORE_W  accumulated scroll distance, saturating
- state  out  2  0 = IDLE, 1 = FLY, 2 = DEAD
- game_over  out  1  high while in DEAD

## Operation
- Reset (overrides every other input): state IDLE, pos = (START_X, START_Y), vel_y 0, scroll_dy 0, scroll_valid 0, score 0, game_over 0.
- IDLE:
  - `frame_tick` has no effect.
  - `start` → FLY with vel_y = -JUMP_V. Position is unchanged that cycle.
  - If `start` and `frame_tick` arrive together, `start` wins and no motion occurs.
- FLY, on each `frame_tick`, using the registered values:
  - Horizontal:
    - dx = -X_STEP if only `left` is high; +X_STEP if only `right` is high; 0 if both or neither.
    - x_n = pos_x + dx, computed at COORD_W+1 signed width.
    - If x_n > X_MAX-SPRITE_W, pos_x ← X_MIN.
    - Else if x_n < X_MIN, pos_x ← X_MAX-SPRITE_W.
    - Otherwise pos_x ← x_n.
  - Vertical position:
    - y_n = pos_y + vel_y (old velocity), computed at COORD_W+1 signed width.
  - Velocity:
    - If `plat_hit` and vel_y > 0, vel_y ← -JUMP_V (bounce).
    - Otherwise vel_y ← min(vel_y + GRAVITY, VMAX_DOWN).
    - `plat_hit` is ignored while vel_y ≤ 0.
  - Scroll:
    - If y_n < SCROLL_LINE: pos_y ← SCROLL_LINE, scroll_dy ← SCROLL_LINE - y_n, scroll_valid pulses, score ← min(score + scroll_dy, 2^SCORE_W - 1).
    - Otherwise pos_y ← y_n.
  - Death:
    - If y_n > SCREEN_H-SPRITE_H: state ← DEAD, game_over ← 1.
    - pos_y ← SCREEN_H-SPRITE_H. pos_x and vel_y still take their updated values.
- DEAD:
  - `frame_tick` has no effect; all outputs hold.
  - `start` → IDLE with spawn position, vel_y 0, score 0, game_over 0.
- `start` while in FLY is ignored.
- Arithmetic:
  - vel_y saturates into the range [-(2^(VEL_W-1)), 2^(VEL_W-1)-1].
  - JUMP_V must be < 2^(VEL_W-1). Parameter legality is checked by elaboration assertion.

## Timing
- All outputs are registered. An update occurs on the `Clk` edge that samples `frame_tick` high, and is visible the following cycle.
- Latency from `frame_tick` to updated outputs is 1 cycle.
- `scroll_valid` is high for exactly 1 cycle.
- `scroll_dy` holds its value until the next scroll.
- `start` takes effect one cycle after it is sampled.
- Reset asserted mid-frame takes effect at the next edge. A `frame_tick` coincident with Reset is discarded.
- Back-to-back `frame_tick` on consecutive cycles is legal; each one is a full update.

## Test plan
- Reset → state 0, pos (155,160), vel_y 0, score 0, game_over 0. Ten `frame_tick` pulses in IDLE leave everything unchanged.
- Start pulse, then one tick → vel_y -9 after start; after the tick, pos_y 151 and vel_y -8. Ticks continue until vel_y reaches 3, then it stays at 3.
- Bounce:
  - pos_y 150, vel_y 3, plat_hit on the tick → pos_y 153, vel_y -9.
  - vel_y -2 with plat_hit → vel_y -1 (hit ignored).
- Horizontal wrap:
  - pos_x 229, right held, tick → pos_x 80.
  - pos_x 80, left held, tick → pos_x 229.
  - left and right both held → pos_x unchanged.
- Scroll: pos_y 84, vel_y -9, tick → pos_y 80, scroll_dy 5, scroll_valid one cycle, score +5. Score at 65533 plus 5 saturates to 65535.
- Death and restart:
  - pos_y 229, vel_y 3, tick → state 2, game_over 1, pos_y 230.
  - Further ticks change nothing.
  - start → IDLE with spawn values and score 0.
  - Reset during FLY restores the reset values on the next edge.

Source files
------------

// File: rtl/doodle_motion.sv
// doodle_motion: player-motion engine for the Doodle Jump datapath.
// IDLE/FLY/DEAD state machine; one full motion update per frame_tick in FLY.
module doodle_motion #(
    parameter int COORD_W     = 10,
    parameter int VEL_W       = 6,
    parameter int SCORE_W     = 16,
    parameter int SCREEN_H    = 240,
    parameter int SPRITE_W    = 10,
    parameter int SPRITE_H    = 10,
    parameter int X_MIN       = 80,
    parameter int X_MAX       = 239,
    parameter int START_X     = 155,
    parameter int START_Y     = 160,
    parameter int SCROLL_LINE = 80,
    parameter int X_STEP      = 1,
    parameter int GRAVITY     = 1,
    parameter int JUMP_V      = 9,
    parameter int VMAX_DOWN   = 3
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic               left,
    input  logic               right,
    input  logic               start,
    input  logic               plat_hit,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [VEL_W-1:0]   vel_y,
    output logic [COORD_W-1:0] scroll_dy,
    output logic               scroll_valid,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state,
    output logic               game_over
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // Signed working widths: one guard bit for positions, two for velocity.
    localparam int CW = COORD_W + 1;
    localparam int VW = VEL_W + 2;
    localparam int SW = SCORE_W + 1;

    localparam logic signed [CW-1:0]    X_LO_S     = CW'(X_MIN);
    localparam logic signed [CW-1:0]    X_HI_S     = CW'(X_MAX - SPRITE_W);
    localparam logic signed [CW-1:0]    X_STEP_S   = CW'(X_STEP);
    localparam logic signed [CW-1:0]    SCROLL_S   = CW'(SCROLL_LINE);
    localparam logic signed [CW-1:0]    FLOOR_S    = CW'(SCREEN_H - SPRITE_H);
    localparam logic signed [VW-1:0]    GRAV_S     = VW'(GRAVITY);
    localparam logic signed [VW-1:0]    VMAX_S     = VW'(VMAX_DOWN);
    localparam logic signed [VW-1:0]    VEL_HI_S   = VW'(2 ** (VEL_W - 1) - 1);
    localparam logic signed [VW-1:0]    VEL_LO_S   = VW'(-(2 ** (VEL_W - 1)));
    localparam logic signed [VEL_W-1:0] JUMP_VEL   = VEL_W'(-JUMP_V);
    localparam logic [COORD_W-1:0]      SPAWN_X    = COORD_W'(START_X);
    localparam logic [COORD_W-1:0]      SPAWN_Y    = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0]      SCROLL_Y   = COORD_W'(SCROLL_LINE);
    localparam logic [COORD_W-1:0]      FLOOR_Y    = COORD_W'(SCREEN_H - SPRITE_H);

    // Parameter legality, caught at elaboration.
    if (JUMP_V <= 0 || JUMP_V >= 2 ** (VEL_W - 1)) begin : g_bad_jump
        $error("doodle_motion: JUMP_V must lie in 1 .. 2**(VEL_W-1)-1");
    end
    if (VMAX_DOWN <= 0 || VMAX_DOWN >= 2 ** (VEL_W - 1)) begin : g_bad_vmax
        $error("doodle_motion: VMAX_DOWN must lie in 1 .. 2**(VEL_W-1)-1");
    end
    if (X_MIN >= X_MAX - SPRITE_W || X_MAX >= 2 ** COORD_W) begin : g_bad_x
        $error("doodle_motion: horizontal playfield bounds are inconsistent");
    end
    if (SCROLL_LINE > SCREEN_H - SPRITE_H || SCREEN_H >= 2 ** COORD_W) begin : g_bad_y
        $error("doodle_motion: vertical playfield bounds are inconsistent");
    end

    state_t                    state_q;
    logic [COORD_W-1:0]        pos_x_q, pos_y_q, scroll_dy_q;
    logic signed [VEL_W-1:0]   vel_y_q;
    logic                      scroll_valid_q, game_over_q;
    logic [SCORE_W-1:0]        score_q;

    logic signed [CW-1:0]      dx, x_sum, y_sum, scroll_amt;
    logic signed [VW-1:0]      vel_sum, vel_cap;
    logic [COORD_W-1:0]        pos_x_d;
    logic signed [VEL_W-1:0]   vel_y_d;
    logic [SW-1:0]             score_sum;
    logic [SCORE_W-1:0]        score_d;
    logic                      falling;

    // Frame datapath: candidate position, velocity and score for a FLY update.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch can be inferred.
        dx = '0;
        if (right && !left) dx = X_STEP_S;
        if (left && !right) dx = -X_STEP_S;

        x_sum = $signed({1'b0, pos_x_q}) + dx;
        if (x_sum > X_HI_S)      pos_x_d = X_LO_S[COORD_W-1:0];
        else if (x_sum < X_LO_S) pos_x_d = X_HI_S[COORD_W-1:0];
        else                     pos_x_d = x_sum[COORD_W-1:0];

        y_sum = $signed({1'b0, pos_y_q}) + CW'(vel_y_q);

        vel_sum = VW'(vel_y_q) + GRAV_S;
        vel_cap = (vel_sum > VMAX_S) ? VMAX_S : vel_sum;
        if (vel_cap > VEL_HI_S) vel_cap = VEL_HI_S;
        if (vel_cap < VEL_LO_S) vel_cap = VEL_LO_S;
        falling = !vel_y_q[VEL_W-1] && (vel_y_q != '0);
        vel_y_d = (plat_hit && falling) ? JUMP_VEL : vel_cap[VEL_W-1:0];

        scroll_amt = SCROLL_S - y_sum;
        score_sum  = {1'b0, score_q} + SW'(scroll_amt[COORD_W-1:0]);
        score_d    = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

    // Game state machine with all outputs registered.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (Reset) begin
            state_q        <= ST_IDLE;
            pos_x_q        <= SPAWN_X;
            pos_y_q        <= SPAWN_Y;
            vel_y_q        <= '0;
            scroll_dy_q    <= '0;
            scroll_valid_q <= 1'b0;
            score_q        <= '0;
            game_over_q    <= 1'b0;
        end else begin
            scroll_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FLY;
                        vel_y_q <= JUMP_VEL;
                    end
                end
                ST_FLY: begin
                    if (frame_tick) begin
                        pos_x_q <= pos_x_d;
                        vel_y_q <= vel_y_d;
                        if (y_sum < SCROLL_S) begin
                            pos_y_q        <= SCROLL_Y;
                            scroll_dy_q    <= scroll_amt[COORD_W-1:0];
                            scroll_valid_q <= 1'b1;
                            score_q        <= score_d;
                        end else if (y_sum > FLOOR_S) begin
                            pos_y_q     <= FLOOR_Y;
                            state_q     <= ST_DEAD;
                            game_over_q <= 1'b1;
                        end else begin
                            pos_y_q <= y_sum[COORD_W-1:0];
                        end
                    end
                end
                ST_DEAD: begin
                    if (start) begin
                        state_q     <= ST_IDLE;
                        pos_x_q     <= SPAWN_X;
                        pos_y_q     <= SPAWN_Y;
                        vel_y_q     <= '0;
                        score_q     <= '0;
                        game_over_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign vel_y        = vel_y_q;
    assign scroll_dy    = scroll_dy_q;
    assign scroll_valid = scroll_valid_q;
    assign score        = score_q;
    assign state        = state_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_doodle_motion.sv
// tb_doodle_motion: directed and randomized stimulus against a frame-level
// behavioural model of the player motion rules.
module tb_doodle_motion;

    localparam int SPAWN_X  = 155;
    localparam int SPAWN_Y  = 160;
    localparam int X_LEFT   = 80;
    localparam int X_RIGHT  = 229;   // X_MAX - SPRITE_W
    localparam int TOP_LINE = 80;
    localparam int FLOOR    = 230;   // SCREEN_H - SPRITE_H
    localparam int JUMP     = 9;
    localparam int TERMINAL = 3;
    localparam int SCORE_MAX = 65535;

    logic        Clk = 1'b0;
    logic        Reset, frame_tick, left, right, start, plat_hit;
    logic [9:0]  pos_x, pos_y, scroll_dy;
    logic [5:0]  vel_y;
    logic        scroll_valid, game_over;
    logic [15:0] score;
    logic [1:0]  state;

    doodle_motion dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .left         (left),
        .right        (right),
        .start        (start),
        .plat_hit     (plat_hit),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .vel_y        (vel_y),
        .scroll_dy    (scroll_dy),
        .scroll_valid (scroll_valid),
        .score        (score),
        .state        (state),
        .game_over    (game_over)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the game: 0 idle, 1 flying, 2 dead.
    int m_state, m_x, m_y, m_v, m_dy, m_valid, m_score, m_go;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = SPAWN_X; m_y = SPAWN_Y; m_v = 0;
        m_dy = 0; m_valid = 0; m_score = 0; m_go = 0;
    endtask

    task automatic model_edge(input bit rst, input bit tick, input bit l, input bit r,
                              input bit hit, input bit st);
        int dx, xn, yn;
        if (rst) begin
            model_reset();
            return;
        end
        m_valid = 0;
        if (m_state == 0) begin
            if (st) begin m_state = 1; m_v = -JUMP; end
        end else if (m_state == 1) begin
            if (tick) begin
                dx = (l == r) ? 0 : (l ? -1 : 1);
                xn = m_x + dx;
                m_x = (xn > X_RIGHT) ? X_LEFT : (xn < X_LEFT) ? X_RIGHT : xn;
                yn = m_y + m_v;
                if (hit && m_v > 0) m_v = -JUMP;
                else                m_v = (m_v + 1 > TERMINAL) ? TERMINAL : m_v + 1;
                if (yn < TOP_LINE) begin
                    m_y = TOP_LINE;
                    m_dy = TOP_LINE - yn;
                    m_valid = 1;
                    m_score = (m_score + m_dy > SCORE_MAX) ? SCORE_MAX : m_score + m_dy;
                end else if (yn > FLOOR) begin
                    m_y = FLOOR; m_state = 2; m_go = 1;
                end else begin
                    m_y = yn;
                end
            end
        end else begin
            if (st) begin
                m_state = 0; m_x = SPAWN_X; m_y = SPAWN_Y; m_v = 0; m_score = 0; m_go = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pos_x"},        int'(pos_x),           m_x);
        check({tag, ".pos_y"},        int'(pos_y),           m_y);
        check({tag, ".vel_y"},        int'($signed(vel_y)),  m_v);
        check({tag, ".scroll_dy"},    int'(scroll_dy),       m_dy);
        check({tag, ".scroll_valid"}, int'(scroll_valid),    m_valid);
        check({tag, ".score"},        int'(score),           m_score);
        check({tag, ".state"},        int'(state),           m_state);
        check({tag, ".game_over"},    int'(game_over),       m_go);
    endtask

    // One clock cycle: drive, clock, advance model, sample 1 time unit later.
    task automatic step(input bit rst, input bit tick, input bit l, input bit r,
                        input bit hit, input bit st, input string tag);
        Reset = rst; frame_tick = tick; left = l; right = r; plat_hit = hit; start = st;
        @(posedge Clk);
        model_edge(rst, tick, l, r, hit, st);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int n, prev_y, prev_x;
        bit rl, rr, rh, rt, rs, rrst;
        model_reset();

        // Reset, including a tick coincident with reset.
        step(1, 0, 0, 0, 0, 0, "reset");
        step(1, 1, 1, 0, 1, 0, "reset_tick");
        check("reset.pos_x", int'(pos_x), 155);
        check("reset.pos_y", int'(pos_y), 160);
        check("reset.state", int'(state), 0);

        // Ticks in IDLE change nothing.
        for (int i = 0; i < 10; i++)
            step(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 0, "idle_tick");
        check("idle.pos_y", int'(pos_y), 160);
        check("idle.vel_y", int'($signed(vel_y)), 0);

        // Start coincident with a tick: start wins, no motion.
        step(0, 1, 0, 1, 0, 1, "start_tick");
        check("start.vel_y", int'($signed(vel_y)), -9);
        check("start.pos_x", int'(pos_x), 155);
        step(0, 1, 0, 0, 0, 0, "first_tick");
        check("first.pos_y", int'(pos_y), 151);
        check("first.vel_y", int'($signed(vel_y)), -8);

        // Rise, apex and fall to terminal velocity.
        n = 0;
        while (m_v != TERMINAL && n < 30) begin
            step(0, 1, 0, 0, 0, 0, "gravity");
            n++;
        end
        check("gravity.bound", n < 30 ? 1 : 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, "terminal");
        check("terminal.vel_y", int'($signed(vel_y)), 3);

        // Bounce while falling.
        prev_y = int'(pos_y);
        step(0, 1, 0, 0, 1, 0, "bounce");
        check("bounce.vel_y", int'($signed(vel_y)), -9);
        check("bounce.pos_y", int'(pos_y), prev_y + 3);

        // Platform contact while rising is ignored.
        n = 0;
        while (m_v != -2 && n < 20) begin
            step(0, 1, 0, 0, 0, 0, "rise");
            n++;
        end
        step(0, 1, 0, 0, 1, 0, "hit_rising");
        check("hit_rising.vel_y", int'($signed(vel_y)), -1);

        // Start while flying is ignored.
        step(0, 0, 0, 0, 0, 1, "start_in_fly");
        check("start_in_fly.state", int'(state), 1);

        // Horizontal wrap at both edges, bouncing as soon as possible to stay alive.
        n = 0;
        while (m_x != X_RIGHT && n < 200) begin
            step(0, 1, 0, 1, m_v > 0, 0, "walk_right");
            n++;
        end
        step(0, 1, 0, 1, m_v > 0, 0, "wrap_right");
        check("wrap_right.pos_x", int'(pos_x), 80);
        step(0, 1, 1, 0, m_v > 0, 0, "wrap_left");
        check("wrap_left.pos_x", int'(pos_x), 229);
        step(0, 1, 1, 1, m_v > 0, 0, "both_keys");
        check("both_keys.pos_x", int'(pos_x), 229);

        // Randomized play, with gaps between ticks, restarts and occasional reset.
        for (int i = 0; i < 600; i++) begin
            rt   = ($urandom % 4) != 0;
            rl   = 1'($urandom);
            rr   = 1'($urandom);
            rh   = (m_v > 0) ? (($urandom % 8) != 0) : 1'($urandom);
            rs   = ($urandom % 16) == 0;
            rrst = ($urandom % 250) == 0;
            step(rrst, rt, rl, rr, rh, rs, "random");
        end

        // Sustained climbing until the score saturates.
        step(1, 0, 0, 0, 0, 0, "sat_reset");
        step(0, 0, 0, 0, 0, 1, "sat_start");
        n = 0;
        while (m_score < SCORE_MAX && n < 40000) begin
            step(0, 1, 1'($urandom), 1'($urandom), m_v > 0, 0, "climb");
            n++;
        end
        check("climb.bound", n < 40000 ? 1 : 0, 1);
        check("saturate.score", int'(score), 65535);
        n = 0;
        while (m_valid == 0 && n < 20) begin
            step(0, 1, 0, 0, m_v > 0, 0, "sat_more");
            n++;
        end
        check("sat_more.score", int'(score), 65535);
        check("sat_more.scroll_valid", int'(scroll_valid), 1);
        step(0, 0, 0, 0, 0, 0, "scroll_hold");
        check("scroll_hold.scroll_valid", int'(scroll_valid), 0);

        // Fall to death; dead state holds through ticks; start restarts.
        n = 0;
        while (m_state != 2 && n < 300) begin
            step(0, 1, 0, 0, 0, 0, "fall");
            n++;
        end
        check("death.state", int'(state), 2);
        check("death.game_over", int'(game_over), 1);
        check("death.pos_y", int'(pos_y), 230);
        prev_x = int'(pos_x);
        for (int i = 0; i < 5; i++)
            step(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 0, "dead_tick");
        check("dead.pos_x", int'(pos_x), prev_x);
        check("dead.pos_y", int'(pos_y), 230);
        step(0, 0, 0, 0, 0, 1, "restart");
        check("restart.state", int'(state), 0);
        check("restart.score", int'(score), 0);
        check("restart.pos_y", int'(pos_y), 160);

        // Reset while flying, coincident with a tick.
        step(0, 0, 0, 0, 0, 1, "fly_again");
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 0, "fly_tick");
        step(1, 1, 0, 1, 0, 0, "fly_reset");
        check("fly_reset.state", int'(state), 0);
        check("fly_reset.pos_x", int'(pos_x), 155);
        check("fly_reset.vel_y", int'($signed(vel_y)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
